// File: rtl/packer_2b_a_8b_pkg.sv
// Shared constants and assembler state encoding for the 2-bit symbol packer.
package packer_2b_a_8b_pkg;

  localparam int unsigned SymW        = 2;
  localparam int unsigned DefSymbols  = 4;
  localparam int unsigned DefOutDepth = 2;
  localparam int unsigned CntW        = 4;

  typedef enum logic {
    StCollect = 1'b0,
    StLast    = 1'b1
  } asm_state_e;

endpackage

// File: rtl/packer_2b_a_8b_if.sv
// Symbol input, word output and status signals of the packer.
// PACKER_PARITY_EN adds parity_out.
interface packer_2b_a_8b_if #(
  parameter int unsigned W = 8
);
  import packer_2b_a_8b_pkg::*;

  logic            valid_in;
  logic [SymW-1:0] data_in;
  logic            flush;
  logic            ready_out;
  logic            overflow_clr;
  logic            valid_out;
  logic [W-1:0]    data_out;
  logic [2:0]      sym_cnt;
  logic [CntW-1:0] fifo_cnt;
  logic            overflow;
`ifdef PACKER_PARITY_EN
  logic            parity_out;

  modport slave (
    input  valid_in, data_in, flush, ready_out, overflow_clr,
    output valid_out, data_out, sym_cnt, fifo_cnt, overflow, parity_out
  );
  modport master (
    output valid_in, data_in, flush, ready_out, overflow_clr,
    input  valid_out, data_out, sym_cnt, fifo_cnt, overflow, parity_out
  );
`else
  modport slave (
    input  valid_in, data_in, flush, ready_out, overflow_clr,
    output valid_out, data_out, sym_cnt, fifo_cnt, overflow
  );
  modport master (
    output valid_in, data_in, flush, ready_out, overflow_clr,
    input  valid_out, data_out, sym_cnt, fifo_cnt, overflow
  );
`endif

endinterface

// File: rtl/packer_2b_a_8b_fifo.sv
// Register-based output FIFO; no bypass, so a push into an empty FIFO is visible next cycle.
module packer_fifo
  import packer_2b_a_8b_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            push,
  input  logic [Width-1:0] din,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count,
  output logic [Width-1:0] dout
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so a push into a full FIFO still succeeds.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/packer_2b_a_8b.sv
// Packs SYMBOLS 2-bit symbols LSB-first into a word and queues it for a valid/ready consumer.
// PACKER_PARITY_EN stores even parity with each word and drives parity_out.
module packer_2b_a_8b
  import packer_2b_a_8b_pkg::*;
#(
  parameter int unsigned SYMBOLS   = DefSymbols,
  parameter int unsigned OUT_DEPTH = DefOutDepth
) (
  input logic            clk,
  input logic            reset_L,
  packer_2b_a_8b_if.slave bus
);

  localparam int unsigned W     = SymW * SYMBOLS;
  localparam int unsigned PartW = W - SymW;
`ifdef PACKER_PARITY_EN
  localparam int unsigned FifoW = W + 1;
`else
  localparam int unsigned FifoW = W;
`endif

  asm_state_e       state_q, state_d;
  logic [2:0]       sym_cnt_q, sym_cnt_d;
  logic [PartW-1:0] part_q, part_d;
  logic [W-1:0]     word;
  logic             push, pop, full, empty, drop;
  logic             overflow_q, overflow_d;
  logic [FifoW-1:0] fifo_din, fifo_dout;
  logic [CntW-1:0]  fifo_count;

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    part_d    = part_q;
    push      = 1'b0;
    word      = {bus.data_in, part_q};
    if (bus.flush) begin
      state_d   = StCollect;
      sym_cnt_d = '0;
      part_d    = '0;
    end else if (bus.valid_in) begin
      unique case (state_q)
        StCollect: begin
          for (int unsigned k = 0; k < SYMBOLS - 1; k++) begin
            if (sym_cnt_q == 3'(k)) part_d[SymW*k +: SymW] = bus.data_in;
          end
          sym_cnt_d = sym_cnt_q + 3'd1;
          state_d   = (sym_cnt_q == 3'(SYMBOLS - 2)) ? StLast : StCollect;
        end
        StLast: begin
          push      = 1'b1;
          sym_cnt_d = '0;
          part_d    = '0;
          state_d   = StCollect;
        end
        default: state_d = StCollect;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StCollect;
      sym_cnt_q  <= '0;
      part_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      part_q     <= part_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop  = bus.ready_out && !empty;
  // The mux side cannot be stalled, so a word arriving at a full, non-draining FIFO is lost.
  assign drop = push && full && !pop;
  assign overflow_d = drop || (overflow_q && !bus.overflow_clr);

`ifdef PACKER_PARITY_EN
  assign fifo_din       = {^word, word};
  assign bus.parity_out = fifo_dout[W];
`else
  assign fifo_din = word;
`endif

  packer_fifo #(
    .Width (FifoW),
    .Depth (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count),
    .dout    (fifo_dout)
  );

  assign bus.valid_out = !empty;
  assign bus.data_out  = fifo_dout[W-1:0];
  assign bus.sym_cnt   = sym_cnt_q;
  assign bus.fifo_cnt  = fifo_count;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_packer_2b_a_8b.sv
// Directed bench for packer_2b_a_8b with SYMBOLS=4, OUT_DEPTH=2.
module tb_packer_2b_a_8b;

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  packer_2b_a_8b_if #(.W(8)) bus ();

  packer_2b_a_8b #(
    .SYMBOLS   (4),
    .OUT_DEPTH (2)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the n lowest symbols of w, LSB-first, one per cycle.
  task automatic send_syms(input logic [7:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = w[2*k +: 2];
      step();
    end
    bus.valid_in = 1'b0;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_L          = 1'b1;
    bus.valid_in     = 1'b0;
    bus.data_in      = 2'b00;
    bus.flush        = 1'b0;
    bus.ready_out    = 1'b0;
    bus.overflow_clr = 1'b0;
    #2 reset_L = 1'b0;
    step();
    step();
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_sym_cnt", 32'(bus.sym_cnt), 32'd0);
    chk("rst_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    reset_L = 1'b1;
    step();

    // Basic word 01,10,11,00 -> 8'b00111001
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = 2'b01;
    step();
    chk("t1_sym1", 32'(bus.sym_cnt), 32'd1);
    bus.data_in = 2'b10;
    step();
    chk("t1_sym2", 32'(bus.sym_cnt), 32'd2);
    bus.data_in = 2'b11;
    step();
    chk("t1_sym3", 32'(bus.sym_cnt), 32'd3);
    chk("t1_not_yet_valid", 32'(bus.valid_out), 32'd0);
    bus.data_in = 2'b00;
    step();
    bus.valid_in = 1'b0;
    chk("t1_sym0", 32'(bus.sym_cnt), 32'd0);
    chk("t1_valid", 32'(bus.valid_out), 32'd1);
    chk("t1_data", 32'(bus.data_out), 32'h39);
    step();
    chk("t1_valid_one_cycle", 32'(bus.valid_out), 32'd0);
    chk("t1_data_empty", 32'(bus.data_out), 32'd0);

    // Backpressure: third word dropped
    bus.ready_out = 1'b0;
    send_syms(8'hE4, 4);
    chk("t2_cnt1", 32'(bus.fifo_cnt), 32'd1);
    chk("t2_data_e4", 32'(bus.data_out), 32'hE4);
    send_syms(8'h1B, 4);
    chk("t2_cnt2", 32'(bus.fifo_cnt), 32'd2);
    chk("t2_no_ovf_yet", 32'(bus.overflow), 32'd0);
    send_syms(8'hFF, 4);
    chk("t2_cnt_full", 32'(bus.fifo_cnt), 32'd2);
    chk("t2_ovf_set", 32'(bus.overflow), 32'd1);
    chk("t2_data_stable", 32'(bus.data_out), 32'hE4);
    bus.ready_out = 1'b1;
    step();
    chk("t2_second_1b", 32'(bus.data_out), 32'h1B);
    chk("t2_cnt_after_pop", 32'(bus.fifo_cnt), 32'd1);
    step();
    chk("t2_empty", 32'(bus.valid_out), 32'd0);
    chk("t2_no_ff", 32'(bus.fifo_cnt), 32'd0);
    chk("t2_ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.overflow_clr = 1'b1;
    step();
    bus.overflow_clr = 1'b0;
    chk("t2_ovf_clr", 32'(bus.overflow), 32'd0);

    // Full FIFO, final symbol coincides with a pop
    bus.ready_out = 1'b0;
    send_syms(8'h12, 4);
    send_syms(8'h34, 4);
    chk("t3_full", 32'(bus.fifo_cnt), 32'd2);
    send_syms(8'h56, 3);
    chk("t3_sym3", 32'(bus.sym_cnt), 32'd3);
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = 2'b01;
    step();
    bus.valid_in = 1'b0;
    chk("t3_cnt_held", 32'(bus.fifo_cnt), 32'd2);
    chk("t3_no_ovf", 32'(bus.overflow), 32'd0);
    chk("t3_data_34", 32'(bus.data_out), 32'h34);
    step();
    chk("t3_data_56", 32'(bus.data_out), 32'h56);
    step();
    chk("t3_drained", 32'(bus.fifo_cnt), 32'd0);

    // Flush beats a coincident valid symbol
    bus.ready_out = 1'b0;
    send_syms(8'h09, 2);
    chk("t4_sym2", 32'(bus.sym_cnt), 32'd2);
    bus.flush    = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in  = 2'b11;
    step();
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    chk("t4_flushed", 32'(bus.sym_cnt), 32'd0);
    chk("t4_fifo_untouched", 32'(bus.fifo_cnt), 32'd0);
    send_syms(8'hFF, 4);
    chk("t4_one_word", 32'(bus.fifo_cnt), 32'd1);
    chk("t4_data_ff", 32'(bus.data_out), 32'hFF);
    bus.ready_out = 1'b1;
    step();
    chk("t4_drained", 32'(bus.valid_out), 32'd0);

    // Asynchronous reset mid-word with a word queued
    bus.ready_out = 1'b0;
    send_syms(8'hAA, 4);
    send_syms(8'h0F, 2);
    chk("t5_pre_cnt", 32'(bus.fifo_cnt), 32'd1);
    chk("t5_pre_sym", 32'(bus.sym_cnt), 32'd2);
    #2 reset_L = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.valid_out), 32'd0);
    chk("t5_async_data", 32'(bus.data_out), 32'd0);
    chk("t5_async_sym", 32'(bus.sym_cnt), 32'd0);
    chk("t5_async_cnt", 32'(bus.fifo_cnt), 32'd0);
    step();
    reset_L = 1'b1;
    step();
    step();
    chk("t5_post_valid", 32'(bus.valid_out), 32'd0);
    chk("t5_post_cnt", 32'(bus.fifo_cnt), 32'd0);

`ifdef PACKER_PARITY_EN
    bus.ready_out = 1'b0;
    send_syms(8'h07, 4);
    chk("t6_par_07", 32'(bus.parity_out), 32'd1);
    bus.ready_out = 1'b1;
    step();
    chk("t6_par_empty", 32'(bus.parity_out), 32'd0);
    bus.ready_out = 1'b0;
    send_syms(8'h03, 4);
    chk("t6_data_03", 32'(bus.data_out), 32'h03);
    chk("t6_par_03", 32'(bus.parity_out), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packer_2b_a_8b.md
Name: packer_2b_a_8b

Overview:
- Downstream stage of the 2-bit registered 2:1 multiplexer.
- Consumes the mux's 2-bit output symbols, qualified by a valid strobe, and packs N consecutive symbols into one word.
- Words are presented on a valid/ready output port backed by a small output FIFO.
- A sticky overflow flag reports dropped words, since the mux side has no backpressure.

Parameters:
- SYMBOLS, 4, number of 2-bit symbols per output word; legal range 2..8. Word width W = 2*SYMBOLS.
- OUT_DEPTH, 2, output FIFO depth in words; legal range 2..8, power of two.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in carries a symbol this cycle.
- data_in  input  2  symbol from the mux output.
- flush  input  1  discard the partial word in progress.
- ready_out  input  1  consumer accepts data_out this cycle.
- overflow_clr  input  1  clears the overflow flag.
- valid_out  output  1  data_out holds a word.
- data_out  output  W  oldest word in the FIFO.
- sym_cnt  output  3  symbols held in the partial word.
- fifo_cnt  output  4  words stored in the FIFO.
- overflow  output  1  sticky: at least one completed word was dropped.

Behaviour:
- Reset (reset_L=0, asynchronous): valid_out=0, data_out=0, sym_cnt=0, fifo_cnt=0, overflow=0. The shift register and FIFO pointers are cleared. Release is synchronous to clk, taking effect on the first posedge with reset_L=1.
- Packing order is LSB-first: the first symbol lands in bits [1:0], symbol k in [2k+1:2k].
- Assembler states:
  - COLLECT: sym_cnt < SYMBOLS-1.
  - LAST: sym_cnt == SYMBOLS-1.
  - Transitions:
    - valid_in in COLLECT: store the symbol, sym_cnt+1.
    - valid_in in LAST: word complete, sym_cnt -> 0, word pushed to FIFO.
    - valid_in=0: hold.
- Latency: the word appears on data_out with valid_out=1 one clock after the posedge that accepted its final symbol, provided the FIFO was empty.
- Output handshake:
  - A transfer occurs on a posedge with valid_out && ready_out.
  - data_out is stable while valid_out=1 && ready_out=0.
  - valid_out never depends combinationally on ready_out.
  - data_out = 0 when empty.
- FIFO push when full:
  - If a pop occurs the same cycle, the push succeeds and fifo_cnt is unchanged.
  - Otherwise the word is dropped and overflow is set next cycle.
  - The assembler always restarts at sym_cnt=0; it never stalls.
- Simultaneous push and pop on an empty FIFO: no bypass. The push is stored and valid_out rises next cycle.
- flush:
  - sym_cnt -> 0 and partial data is discarded.
  - Has priority over valid_in in the same cycle; that symbol is also discarded.
  - Does not affect FIFO contents or the output handshake.
- overflow_clr: clears overflow next cycle. If a drop happens in the same cycle, set wins and overflow stays 1.
- Pointers wrap modulo OUT_DEPTH. fifo_cnt ranges 0..OUT_DEPTH.
- X on data_in while valid_in=0 has no effect.
- Reset asserted mid-word or mid-transfer: all state is lost immediately and asynchronously; no word is emitted.

Optional Feature:
- Macro: PACKER_PARITY_EN.
- Defined:
  - Adds output port parity_out (1 bit): even parity (XOR) of the word currently on data_out.
  - Parity is computed at push and stored in the FIFO alongside the word.
  - parity_out = 0 when empty or in reset.
- Undefined: no port, no extra storage. Behaviour is otherwise identical.

Decomposition:
- Shared include file (guarded by `ifndef):
  - symbol width constant (2)
  - default SYMBOLS and OUT_DEPTH
  - fifo_cnt width constant (4)
  - assembler state encodings COLLECT / LAST
- Sub-module packer_fifo, parameterised on width and depth:
  - synchronous-write, registered-output FIFO with push, pop, full, empty and count
  - same clk / reset_L
- The top level holds the assembler, overflow logic and optional parity.

Test Plan:
- Reset sequence, then valid_in=1 for four cycles with data_in 2'b01, 2'b10, 2'b11, 2'b00 (ready_out=1):
  - data_out = 8'b00111001, valid_out=1 for exactly one cycle, one clock after the fourth symbol.
  - sym_cnt sequence 0,1,2,3,0.
- Backpressure, ready_out=0, three words 8'hE4, 8'h1B, 8'hFF sent:
  - fifo_cnt reaches 2 and overflow=1 after the third word.
  - Raise ready_out: E4 then 1B, no FF.
  - overflow_clr pulse -> overflow=0.
- FIFO full with a final symbol arriving in the same cycle as a pop: no drop, overflow stays 0, fifo_cnt stays 2.
- Two symbols sent, then flush together with a third valid symbol, then four symbols 2'b11: only 8'hFF emitted.
- reset_L pulled low mid-cycle with fifo_cnt=1 and sym_cnt=2: outputs go to 0 before the next clk edge; no word appears after release.
- With PACKER_PARITY_EN defined: word 8'h07 -> parity_out=1; word 8'h03 -> parity_out=0.
